// File: rtl/s3g_port_mux.sv
// N-port UART front end: locks s3g_rx to the first port that sends SOF, routes s3g_tx replies to the requester or all ports.
// Latency: rx byte forwarded 1 cycle after its strobe; tx strobe 1 cycle after tx_wr. No backpressure: rx bytes are forwarded or dropped, tx_wr is ignored while busy.
module s3g_port_mux #(
    parameter int         NUM_PORTS    = 2,
    parameter logic [7:0] SOF_BYTE     = 8'hD5,
    parameter int         IDLE_TIMEOUT = 50000,
    parameter bit         TX_BROADCAST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*NUM_PORTS-1:0] port_rx_data,
    input  logic [NUM_PORTS-1:0]   port_rx_done,
    output logic [7:0]             port_tx_data,
    output logic [NUM_PORTS-1:0]   port_tx_wr,
    input  logic [NUM_PORTS-1:0]   port_tx_done,
    output logic [7:0]             rx_data,
    output logic                   rx_done,
    input  logic                   packet_done,
    input  logic                   packet_error,
    input  logic [7:0]             tx_data,
    input  logic                   tx_wr,
    output logic                   tx_done,
    output logic                   locked,
    output logic [2:0]             owner,
    output logic [2:0]             reply_port,
    output logic [15:0]            drop_count
);

    localparam int CW = $clog2(IDLE_TIMEOUT);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t               state_q, state_d;
    logic [2:0]           owner_q, owner_d;
    logic [2:0]           reply_q, reply_d;
    logic                 locked_q, locked_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_done_q, rx_done_d;
    logic [CW-1:0]        idle_q, idle_d;
    logic [15:0]          drop_q, drop_d;
    logic [7:0]           ptx_data_q, ptx_data_d;
    logic [NUM_PORTS-1:0] ptx_wr_q, ptx_wr_d;
    logic [NUM_PORTS-1:0] mask_q, mask_d;
    logic [NUM_PORTS-1:0] seen_q, seen_d;
    logic                 busy_q, busy_d;
    logic                 tx_done_q, tx_done_d;

    logic [NUM_PORTS-1:0] cand, others, uni_mask, new_mask, seen_nxt;
    logic                 win_vld, owner_hit, timeout;
    logic [2:0]           win_idx;
    logic [7:0]           owner_byte;
    logic [3:0]           drop_inc;
    logic [16:0]          drop_sum;

    function automatic logic [3:0] popcnt(input logic [NUM_PORTS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_PORTS; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    // Descending scan so the lowest-index SOF candidate is the one left standing.
    always_comb begin
        cand       = '0;
        others     = '0;
        win_vld    = 1'b0;
        win_idx    = '0;
        owner_hit  = 1'b0;
        owner_byte = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand[i] = port_rx_done[i] && (port_rx_data[8*i +: 8] == SOF_BYTE);
            if (cand[i]) begin
                win_vld = 1'b1;
                win_idx = 3'(i);
            end
            if (owner_q == 3'(i)) begin
                owner_hit  = port_rx_done[i];
                owner_byte = port_rx_data[8*i +: 8];
            end else begin
                others[i] = port_rx_done[i];
            end
        end
    end

    assign timeout = !owner_hit && (idle_q == CW'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (win_vld) state_d = ST_LOCKED;
            ST_LOCKED: if (packet_done || packet_error || timeout) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        owner_d   = owner_q;
        reply_d   = reply_q;
        rx_data_d = rx_data_q;
        rx_done_d = 1'b0;
        idle_d    = idle_q;
        drop_inc  = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    owner_d   = win_idx;
                    reply_d   = win_idx;
                    rx_data_d = SOF_BYTE;
                    rx_done_d = 1'b1;
                    idle_d    = '0;
                    drop_inc  = popcnt(cand) - 4'd1;
                end
            end
            ST_LOCKED: begin
                drop_inc = popcnt(others);
                if (owner_hit) begin
                    rx_data_d = owner_byte;
                    rx_done_d = 1'b1;
                    idle_d    = '0;
                end else begin
                    idle_d    = idle_q + CW'(1);
                end
                if (state_d == ST_IDLE) idle_d = '0;
            end
            default: ;
        endcase
        locked_d = (state_d == ST_LOCKED);
        drop_sum = {1'b0, drop_q} + {13'd0, drop_inc};
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) uni_mask[i] = (reply_q == 3'(i));
        new_mask   = TX_BROADCAST ? {NUM_PORTS{1'b1}} : uni_mask;
        seen_nxt   = seen_q | (port_tx_done & mask_q);
        ptx_data_d = ptx_data_q;
        ptx_wr_d   = '0;
        mask_d     = mask_q;
        seen_d     = seen_q;
        busy_d     = busy_q;
        tx_done_d  = 1'b0;
        if (!busy_q) begin
            if (tx_wr) begin
                ptx_data_d = tx_data;
                mask_d     = new_mask;
                ptx_wr_d   = new_mask;
                seen_d     = '0;
                busy_d     = 1'b1;
            end
        end else if (seen_nxt == mask_q) begin
            tx_done_d = 1'b1;
            busy_d    = 1'b0;
            seen_d    = '0;
        end else begin
            seen_d = seen_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= '0;
            reply_q    <= '0;
            locked_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            idle_q     <= '0;
            drop_q     <= '0;
            ptx_data_q <= '0;
            ptx_wr_q   <= '0;
            mask_q     <= '0;
            seen_q     <= '0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            reply_q    <= reply_d;
            locked_q   <= locked_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
            idle_q     <= idle_d;
            drop_q     <= drop_d;
            ptx_data_q <= ptx_data_d;
            ptx_wr_q   <= ptx_wr_d;
            mask_q     <= mask_d;
            seen_q     <= seen_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign port_tx_data = ptx_data_q;
    assign port_tx_wr   = ptx_wr_q;
    assign rx_data      = rx_data_q;
    assign rx_done      = rx_done_q;
    assign tx_done      = tx_done_q;
    assign locked       = locked_q;
    assign owner        = owner_q;
    assign reply_port   = reply_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_s3g_port_mux.sv
// Bench for s3g_port_mux: a 2-port unicast instance (a_*) and a 3-port broadcast instance (b_*), both with a 16-cycle lock timeout.
`timescale 1ns/1ps
module tb_s3g_port_mux;

    logic clk;
    logic rst_n;

    logic [15:0] a_port_rx_data;
    logic [1:0]  a_port_rx_done, a_port_tx_wr, a_port_tx_done;
    logic [7:0]  a_port_tx_data, a_rx_data, a_tx_data;
    logic        a_rx_done, a_packet_done, a_packet_error, a_tx_wr, a_tx_done, a_locked;
    logic [2:0]  a_owner, a_reply_port;
    logic [15:0] a_drop_count;

    logic [23:0] b_port_rx_data;
    logic [2:0]  b_port_rx_done, b_port_tx_wr, b_port_tx_done;
    logic [7:0]  b_port_tx_data, b_rx_data, b_tx_data;
    logic        b_rx_done, b_packet_done, b_packet_error, b_tx_wr, b_tx_done, b_locked;
    logic [2:0]  b_owner, b_reply_port;
    logic [15:0] b_drop_count;

    int tests = 0;
    int fails = 0;

    s3g_port_mux #(.NUM_PORTS(2), .SOF_BYTE(8'hD5), .IDLE_TIMEOUT(16), .TX_BROADCAST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .port_rx_data(a_port_rx_data), .port_rx_done(a_port_rx_done),
        .port_tx_data(a_port_tx_data), .port_tx_wr(a_port_tx_wr), .port_tx_done(a_port_tx_done),
        .rx_data(a_rx_data), .rx_done(a_rx_done),
        .packet_done(a_packet_done), .packet_error(a_packet_error),
        .tx_data(a_tx_data), .tx_wr(a_tx_wr), .tx_done(a_tx_done),
        .locked(a_locked), .owner(a_owner), .reply_port(a_reply_port), .drop_count(a_drop_count)
    );

    s3g_port_mux #(.NUM_PORTS(3), .SOF_BYTE(8'hD5), .IDLE_TIMEOUT(16), .TX_BROADCAST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .port_rx_data(b_port_rx_data), .port_rx_done(b_port_rx_done),
        .port_tx_data(b_port_tx_data), .port_tx_wr(b_port_tx_wr), .port_tx_done(b_port_tx_done),
        .rx_data(b_rx_data), .rx_done(b_rx_done),
        .packet_done(b_packet_done), .packet_error(b_packet_error),
        .tx_data(b_tx_data), .tx_wr(b_tx_wr), .tx_done(b_tx_done),
        .locked(b_locked), .owner(b_owner), .reply_port(b_reply_port), .drop_count(b_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_port_rx_data = '0; a_port_rx_done = '0; a_port_tx_done = '0;
        a_packet_done = 1'b0; a_packet_error = 1'b0; a_tx_data = '0; a_tx_wr = 1'b0;
        b_port_rx_data = '0; b_port_rx_done = '0; b_port_tx_done = '0;
        b_packet_done = 1'b0; b_packet_error = 1'b0; b_tx_data = '0; b_tx_wr = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #3;
        tests++; if ({a_port_tx_data, a_port_tx_wr, a_rx_data, a_rx_done, a_tx_done, a_locked, a_owner, a_reply_port, a_drop_count} !== '0) begin
            fails++; $display("FAIL reset_a: outputs %h, want all zero", {a_port_tx_data, a_port_tx_wr, a_rx_data, a_rx_done, a_tx_done, a_locked, a_owner, a_reply_port, a_drop_count}); end
        tests++; if ({b_port_tx_data, b_port_tx_wr, b_rx_data, b_rx_done, b_tx_done, b_locked, b_owner, b_reply_port, b_drop_count} !== '0) begin
            fails++; $display("FAIL reset_b: outputs %h, want all zero", {b_port_tx_data, b_port_tx_wr, b_rx_data, b_rx_done, b_tx_done, b_locked, b_owner, b_reply_port, b_drop_count}); end
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        tests++; if (a_locked !== 1'b0 || a_rx_done !== 1'b0) begin
            fails++; $display("FAIL reset_release: locked=%b rx_done=%b, want 0 0", a_locked, a_rx_done); end
    endtask

    task automatic test_single_port_packet();
        logic [7:0] pkt [5];
        pkt = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            a_port_rx_done = 2'b10;
            a_port_rx_data = {pkt[k], 8'h00};
            cyc();
            a_port_rx_done = 2'b00;
            tests++; if (a_rx_done !== 1'b1 || a_rx_data !== pkt[k]) begin
                fails++; $display("FAIL pkt_fwd k=%0d: rx_done=%b rx_data=%h, want 1 %h", k, a_rx_done, a_rx_data, pkt[k]); end
            tests++; if (a_locked !== 1'b1 || a_owner !== 3'd1) begin
                fails++; $display("FAIL pkt_owner k=%0d: locked=%b owner=%0d, want 1 1", k, a_locked, a_owner); end
            cyc();
            tests++; if (a_rx_done !== 1'b0) begin
                fails++; $display("FAIL pkt_strobe_len k=%0d: rx_done=%b, want 0", k, a_rx_done); end
        end
        a_packet_done = 1'b1;
        cyc();
        a_packet_done = 1'b0;
        tests++; if (a_locked !== 1'b0 || a_reply_port !== 3'd1 || a_drop_count !== 16'd0) begin
            fails++; $display("FAIL pkt_unlock: locked=%b reply=%0d drops=%0d, want 0 1 0", a_locked, a_reply_port, a_drop_count); end
    endtask

    task automatic test_same_cycle_sof();
        logic [7:0] p0 [4];
        logic [7:0] p1 [4];
        p0 = '{8'h03, 8'h10, 8'h11, 8'h12};
        p1 = '{8'h03, 8'h20, 8'h21, 8'h22};
        do_reset();
        a_port_rx_done = 2'b11;
        a_port_rx_data = 16'hD5D5;
        cyc();
        tests++; if (a_locked !== 1'b1 || a_owner !== 3'd0 || a_drop_count !== 16'd1) begin
            fails++; $display("FAIL tie_win: locked=%b owner=%0d drops=%0d, want 1 0 1", a_locked, a_owner, a_drop_count); end
        for (int k = 0; k < 4; k++) begin
            a_port_rx_done = 2'b11;
            a_port_rx_data = {p1[k], p0[k]};
            cyc();
            tests++; if (a_rx_done !== 1'b1 || a_rx_data !== p0[k]) begin
                fails++; $display("FAIL tie_fwd k=%0d: rx_done=%b rx_data=%h, want 1 %h", k, a_rx_done, a_rx_data, p0[k]); end
        end
        a_port_rx_done = 2'b00;
        a_packet_error = 1'b1;
        cyc();
        a_packet_error = 1'b0;
        tests++; if (a_drop_count !== 16'd5 || a_locked !== 1'b0) begin
            fails++; $display("FAIL tie_drops: drops=%0d locked=%b, want 5 0", a_drop_count, a_locked); end
    endtask

    task automatic test_idle_timeout();
        do_reset();
        a_port_rx_done = 2'b01;
        a_port_rx_data = 16'h00D5;
        cyc();
        a_port_rx_done = 2'b00;
        for (int k = 1; k <= 16; k++) begin
            if (k == 8) begin
                a_port_rx_done = 2'b10;
                a_port_rx_data = 16'h4400;
            end
            cyc();
            a_port_rx_done = 2'b00;
            tests++; if (a_locked !== (k < 16)) begin
                fails++; $display("FAIL timeout k=%0d: locked=%b, want %b", k, a_locked, (k < 16)); end
        end
        a_port_rx_done = 2'b10;
        a_port_rx_data = 16'hD500;
        cyc();
        a_port_rx_done = 2'b00;
        tests++; if (a_locked !== 1'b1 || a_owner !== 3'd1 || a_rx_data !== 8'hD5) begin
            fails++; $display("FAIL relock: locked=%b owner=%0d rx_data=%h, want 1 1 d5", a_locked, a_owner, a_rx_data); end
    endtask

    task automatic test_tx_unicast();
        do_reset();
        a_port_rx_done = 2'b10;
        a_port_rx_data = 16'hD500;
        cyc();
        a_port_rx_done = 2'b00;
        a_packet_done  = 1'b1;
        cyc();
        a_packet_done  = 1'b0;
        a_tx_data = 8'hA5;
        a_tx_wr   = 1'b1;
        cyc();
        a_tx_wr   = 1'b0;
        tests++; if (a_port_tx_wr !== 2'b10 || a_port_tx_data !== 8'hA5) begin
            fails++; $display("FAIL uni_wr: port_tx_wr=%b data=%h, want 10 a5", a_port_tx_wr, a_port_tx_data); end
        cyc();
        tests++; if (a_port_tx_wr !== 2'b00) begin
            fails++; $display("FAIL uni_wr_len: port_tx_wr=%b, want 00", a_port_tx_wr); end
        a_tx_wr = 1'b1;
        a_tx_data = 8'h11;
        a_port_rx_done = 2'b01;
        a_port_rx_data = 16'h00D5;
        cyc();
        a_tx_wr = 1'b0;
        a_port_rx_done = 2'b00;
        tests++; if (a_port_tx_wr !== 2'b00 || a_port_tx_data !== 8'hA5 || a_reply_port !== 3'd0) begin
            fails++; $display("FAIL uni_busy: port_tx_wr=%b data=%h reply=%0d, want 00 a5 0", a_port_tx_wr, a_port_tx_data, a_reply_port); end
        a_port_tx_done = 2'b01;
        cyc();
        a_port_tx_done = 2'b00;
        tests++; if (a_tx_done !== 1'b0) begin
            fails++; $display("FAIL uni_nontarget: tx_done=%b, want 0", a_tx_done); end
        a_port_tx_done = 2'b10;
        cyc();
        a_port_tx_done = 2'b00;
        tests++; if (a_tx_done !== 1'b1) begin
            fails++; $display("FAIL uni_done: tx_done=%b, want 1", a_tx_done); end
        cyc();
        tests++; if (a_tx_done !== 1'b0) begin
            fails++; $display("FAIL uni_done_len: tx_done=%b, want 0", a_tx_done); end
        a_tx_data = 8'h5A;
        a_tx_wr   = 1'b1;
        cyc();
        a_tx_wr   = 1'b0;
        tests++; if (a_port_tx_wr !== 2'b01 || a_port_tx_data !== 8'h5A) begin
            fails++; $display("FAIL uni_second: port_tx_wr=%b data=%h, want 01 5a", a_port_tx_wr, a_port_tx_data); end
    endtask

    task automatic test_tx_broadcast();
        logic [2:0] seq [5];
        logic       want [5];
        seq  = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b001};
        want = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        b_tx_data = 8'h3C;
        b_tx_wr   = 1'b1;
        cyc();
        b_tx_wr   = 1'b0;
        tests++; if (b_port_tx_wr !== 3'b111 || b_port_tx_data !== 8'h3C) begin
            fails++; $display("FAIL bc_wr: port_tx_wr=%b data=%h, want 111 3c", b_port_tx_wr, b_port_tx_data); end
        for (int k = 0; k < 5; k++) begin
            b_port_tx_done = seq[k];
            cyc();
            b_port_tx_done = 3'b000;
            tests++; if (b_tx_done !== want[k]) begin
                fails++; $display("FAIL bc_done k=%0d: tx_done=%b, want %b", k, b_tx_done, want[k]); end
        end
    endtask

    task automatic test_reset_midway();
        do_reset();
        a_port_rx_done = 2'b01;
        a_port_rx_data = 16'h00D5;
        cyc();
        a_port_rx_data = 16'h0007;
        a_tx_data = 8'h77;
        a_tx_wr   = 1'b1;
        cyc();
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if ({a_port_tx_data, a_port_tx_wr, a_rx_data, a_rx_done, a_tx_done, a_locked, a_owner, a_reply_port, a_drop_count} !== '0) begin
            fails++; $display("FAIL midreset: outputs %h, want all zero", {a_port_tx_data, a_port_tx_wr, a_rx_data, a_rx_done, a_tx_done, a_locked, a_owner, a_reply_port, a_drop_count}); end
        cyc();
        rst_n = 1'b1;
        a_port_tx_done = 2'b01;
        cyc();
        a_port_tx_done = 2'b00;
        tests++; if (a_tx_done !== 1'b0 || a_rx_done !== 1'b0) begin
            fails++; $display("FAIL midreset_nostrobe: tx_done=%b rx_done=%b, want 0 0", a_tx_done, a_rx_done); end
        a_port_rx_done = 2'b10;
        a_port_rx_data = 16'hD500;
        cyc();
        a_port_rx_done = 2'b00;
        tests++; if (a_locked !== 1'b1 || a_owner !== 3'd1 || a_rx_done !== 1'b1) begin
            fails++; $display("FAIL midreset_relock: locked=%b owner=%0d rx_done=%b, want 1 1 1", a_locked, a_owner, a_rx_done); end
    endtask

    // Reference model: lock to lowest SOF sender, count foreign bytes, release after 16 silent cycles or packet end.
    task automatic test_random_rx();
        bit         m_locked = 0;
        int         m_owner = 0, m_reply = 0, m_silent = 0, m_drops = 0;
        bit         exp_done;
        logic [7:0] exp_data;
        logic [7:0] bb [2];
        logic [1:0] s;
        bit         pd, pe;
        int         prob, win, ncand;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            prob = (((c / 40) % 3) == 2) ? 3 : 40;
            for (int p = 0; p < 2; p++) begin
                s[p]  = ($urandom_range(0, 99) < prob);
                bb[p] = ($urandom_range(0, 3) == 0) ? 8'hD5 : 8'($urandom);
            end
            pd = ($urandom_range(0, 99) < 3);
            pe = ($urandom_range(0, 99) < 2);
            a_port_rx_done = s;
            a_port_rx_data = {bb[1], bb[0]};
            a_packet_done  = pd;
            a_packet_error = pe;
            exp_done = 0;
            exp_data = 8'h00;
            if (!m_locked) begin
                win = -1; ncand = 0;
                for (int p = 0; p < 2; p++)
                    if (s[p] && bb[p] == 8'hD5) begin
                        ncand++;
                        if (win < 0) win = p;
                    end
                if (win >= 0) begin
                    m_locked = 1; m_owner = win; m_reply = win; m_silent = 0;
                    exp_done = 1; exp_data = 8'hD5;
                    m_drops += ncand - 1;
                end
            end else begin
                for (int p = 0; p < 2; p++)
                    if (s[p] && p != m_owner) m_drops++;
                if (s[m_owner]) begin
                    exp_done = 1; exp_data = bb[m_owner]; m_silent = 0;
                end else begin
                    m_silent++;
                end
                if (pd || pe || m_silent >= 16) m_locked = 0;
            end
            if (m_drops > 65535) m_drops = 65535;
            cyc();
            tests++; if (a_rx_done !== exp_done || (exp_done && a_rx_data !== exp_data)) begin
                fails++; $display("FAIL rand_rx c=%0d: rx_done=%b rx_data=%h, want %b %h", c, a_rx_done, a_rx_data, exp_done, exp_data); end
            tests++; if (a_locked !== m_locked || (m_locked && a_owner !== 3'(m_owner))) begin
                fails++; $display("FAIL rand_lock c=%0d: locked=%b owner=%0d, want %b %0d", c, a_locked, a_owner, m_locked, m_owner); end
            tests++; if (a_drop_count !== 16'(m_drops) || a_reply_port !== 3'(m_reply)) begin
                fails++; $display("FAIL rand_cnt c=%0d: drops=%0d reply=%0d, want %0d %0d", c, a_drop_count, a_reply_port, m_drops, m_reply); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_port_packet();
        test_same_cycle_sof();
        test_idle_timeout();
        test_tx_unicast();
        test_tx_broadcast();
        test_reset_midway();
        test_random_rx();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
